// File: rtl/ti_share_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ti_share_encoder
// Description : Threshold-implementation front end. Splits each accepted
//               4-bit plain nibble into SHARES Boolean shares using fresh
//               masks drawn from an internal seeded 16-bit LFSR. The share
//               bundle is held in a single-entry output register that feeds
//               the downstream TI S-box pipeline over valid/ready.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WIDTH         nibble width (only 4 supported)
//               SHARES        number of shares, 2 or 3
//               ZERO_SEED_SUB LFSR value loaded when a zero seed is supplied
// Ports       : clk, rst      clock, asynchronous active-high reset
//               seed_valid    load seed into the LFSR this cycle
//               seed          16-bit LFSR seed
//               in_valid      plain nibble valid
//               in_ready      encoder can accept a nibble
//               in_data       plain nibble x
//               out_valid     share bundle valid
//               out_ready     downstream accepts the bundle
//               out_shares    bundle; share i in bits [4i+3:4i]
//               busy          output bundle pending (== out_valid)
//               share_err     sticky share-consistency error (only when
//                             TI_SHARE_CHECK_EN is defined)
// Options     : TI_SHARE_CHECK_EN - adds a registered copy of x and a sticky
//               check that the XOR of the emitted shares equals x.
// ============================================================================
module ti_share_encoder #(
  parameter int          WIDTH         = 4,
  parameter int          SHARES        = 3,
  parameter logic [15:0] ZERO_SEED_SUB = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seed_valid,
  input  logic [15:0]             seed,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*SHARES-1:0] out_shares,
  output logic                    busy
`ifdef TI_SHARE_CHECK_EN
  ,
  output logic                    share_err
`endif
);

  // --------------------------------------------------------------------------
  // State machine: UNSEEDED until the first seed arrives, then RUN forever
  // (until reset).
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    UNSEEDED = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_in_ready;
  logic                    w_accept;

  logic [15:0]             r_lfsr;
  logic [15:0]             w_lfsr_step8;
  logic [15:0]             w_seed_sub;
  logic [WIDTH-1:0]        w_m1;
  logic [WIDTH*SHARES-1:0] w_bundle;

  logic                    r_out_valid;
  logic [WIDTH*SHARES-1:0] r_out_shares;

  // Eight LFSR steps unrolled so one accept consumes a full byte of fresh
  // pseudo-randomness (two 4-bit masks).
  function automatic logic [15:0] step8(input logic [15:0] l);
    logic [15:0] v;
    v = l;
    for (int i = 0; i < 8; i++) begin
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    end
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= UNSEEDED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      UNSEEDED: begin
        if (seed_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        // Single-entry output register: accept when empty or draining now.
        w_in_ready = ~r_out_valid | out_ready;
      end
      default: begin
        w_state_next = UNSEEDED;
      end
    endcase
  end

  assign w_accept = in_valid & w_in_ready;

  // --------------------------------------------------------------------------
  // Mask generator
  // --------------------------------------------------------------------------
  assign w_lfsr_step8 = step8(r_lfsr);
  // A zero seed would lock the LFSR at zero; substitute a known non-zero value.
  assign w_seed_sub   = (seed == 16'h0000) ? ZERO_SEED_SUB : seed;
  assign w_m1         = w_lfsr_step8[WIDTH-1:0];

  // A seed load wins over the per-accept advance; an input accepted in the
  // same cycle has already used masks derived from the old LFSR value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'h0000;
    end else if (seed_valid) begin
      r_lfsr <= w_seed_sub;
    end else if (w_accept) begin
      r_lfsr <= w_lfsr_step8;
    end
  end

  // --------------------------------------------------------------------------
  // Share split
  // --------------------------------------------------------------------------
  generate
    if (SHARES == 2) begin : g_shares2
      assign w_bundle = {w_m1, in_data ^ w_m1};
    end else begin : g_shares3
      logic [WIDTH-1:0] w_m2;
      assign w_m2     = w_lfsr_step8[2*WIDTH-1:WIDTH];
      assign w_bundle = {w_m2, w_m1, in_data ^ w_m1 ^ w_m2};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output register: a new bundle replaces the old one on a simultaneous
  // drain+accept; otherwise the bundle is held until out_ready.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_shares <= '0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_shares <= w_bundle;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_shares = r_out_shares;
  assign busy       = r_out_valid;

`ifdef TI_SHARE_CHECK_EN
  // --------------------------------------------------------------------------
  // Share-consistency monitor: recombine the held shares and compare against
  // a stored copy of the plain nibble.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] w_recombined;
  logic             w_mismatch;
  logic             r_share_err;

  always_comb begin
    w_recombined = '0;
    for (int i = 0; i < SHARES; i++) begin
      w_recombined = w_recombined ^ r_out_shares[i*WIDTH +: WIDTH];
    end
  end

  assign w_mismatch = r_out_valid & (w_recombined != r_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x         <= '0;
      r_share_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x <= in_data;
      end
      if (w_mismatch) begin
        r_share_err <= 1'b1;
      end
    end
  end

  assign share_err = r_share_err;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && w_mismatch) begin
      $error("ti_share_encoder: share recombination %h != stored x %h",
             w_recombined, r_x);
    end
  end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_ti_share_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ti_share_encoder
// Description : Self-checking bench for ti_share_encoder. A cycle-level
//               behavioural model (LFSR as tap-mask parity, single output
//               slot) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ti_share_encoder;

  localparam int          W   = 4;
  localparam int          SH  = 3;
  localparam int          TW  = W * SH;
  localparam logic [15:0] SUB = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;  // bits 15,13,12,10

  logic          clk = 1'b0;
  logic          rst;
  logic          seed_valid;
  logic [15:0]   seed;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_shares;
  logic          busy;
`ifdef TI_SHARE_CHECK_EN
  logic          share_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic          m_seeded;
  logic [15:0]   m_lfsr;
  logic          m_ov;
  logic [TW-1:0] m_sh;
  logic [W-1:0]  m_x;

  ti_share_encoder #(.WIDTH(W), .SHARES(SH), .ZERO_SEED_SUB(SUB)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares),
    .busy       (busy)
`ifdef TI_SHARE_CHECK_EN
    ,
    .share_err  (share_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_step8(input logic [15:0] l);
    logic [15:0] v;
    v = l;
    for (int i = 0; i < 8; i++) v = {v[14:0], ^(v & TAPS)};
    return v;
  endfunction

  function automatic logic [TW-1:0] ref_encode(input logic [W-1:0] x, input logic [15:0] n);
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] r;
    a = n[3:0];
    b = n[7:4];
    r = '0;
    if (SH == 3) begin
      r[3:0] = x ^ a ^ b;
      r[7:4] = a;
      r[TW-1:8] = b;
    end else begin
      r[3:0] = x ^ a;
      r[7:4] = a;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] recombine(input logic [TW-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < SH; i++) r = r ^ s[i*W +: W];
    return r;
  endfunction

  task automatic model_reset();
    m_seeded = 1'b0;
    m_lfsr   = 16'h0000;
    m_ov     = 1'b0;
    m_sh     = '0;
    m_x      = '0;
  endtask

  task automatic idle_inputs();
    seed_valid = 1'b0;
    seed       = 16'h0000;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
  endtask

  // Inputs are set just after a rising edge; outputs are compared on the
  // falling edge, then the model advances with the values seen at the edge.
  task automatic step_cycle();
    logic        acc;
    logic [15:0] n;
    @(negedge clk);
    check("in_ready", in_ready, (!rst && m_seeded && (!m_ov || out_ready)));
    check("out_valid", out_valid, m_ov);
    check("busy", busy, m_ov);
    check("out_shares", out_shares, m_sh);
    if (out_valid) check("xor_invariant", recombine(out_shares), m_x);
`ifdef TI_SHARE_CHECK_EN
    check("share_err", share_err, 1'b0);
`endif
    acc = !rst && in_valid && m_seeded && (!m_ov || out_ready);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      n = ref_step8(m_lfsr);
      if (acc) begin
        m_sh = ref_encode(in_data, n);
        m_x  = in_data;
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (seed_valid) begin
        m_lfsr   = (seed == 16'h0000) ? SUB : seed;
        m_seeded = 1'b1;
      end else if (acc) begin
        m_lfsr = n;
      end
    end
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_valid = 1'b1;
    seed       = s;
    step_cycle();
    seed_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (3) step_cycle();
    rst = 1'b0;

    // unseeded: input never accepted
    in_valid = 1'b1;
    in_data  = 4'h5;
    out_ready = 1'b1;
    repeat (20) step_cycle();

    // zero seed substitution, two accepts reveal masks
    in_valid = 1'b0;
    load_seed(16'h0000);
    in_valid = 1'b1;
    in_data = 4'h3; step_cycle();
    in_data = 4'hC; step_cycle();
    in_valid = 1'b0;
    step_cycle();

    // streaming 0..15 with full throughput
    load_seed(16'h1234);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = i[W-1:0];
      step_cycle();
    end
    in_valid = 1'b0;
    step_cycle();

    // back-pressure: bundle held for 5 stalled cycles
    in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b0;
    step_cycle();
    in_data = 4'h6;
    repeat (5) step_cycle();
    out_ready = 1'b1;
    step_cycle();
    in_valid = 1'b0;
    step_cycle();

    // seed load coincident with accept
    in_valid = 1'b1; in_data = 4'h9;
    seed_valid = 1'b1; seed = 16'hBEEF;
    step_cycle();
    seed_valid = 1'b0; in_data = 4'h2;
    step_cycle();
    in_valid = 1'b0;
    step_cycle();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_data    = W'($urandom);
      seed_valid = ($urandom_range(0, 15) == 0);
      seed       = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      step_cycle();
    end

    // asynchronous reset with a pending bundle
    idle_inputs();
    in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b0;
    step_cycle();
    in_valid = 1'b0;
    step_cycle();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b0);
    check("async_rst_shares", out_shares, '0);
    model_reset();
    repeat (2) step_cycle();
    rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; in_data = 4'hE;
    repeat (5) step_cycle();
    load_seed(16'h00FF);
    repeat (4) step_cycle();
    idle_inputs();
    step_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
